serial_operand_shifter: RTL and testbench

SERIAL_OPERAND_SHIFTER -- requirements
Module: serial_operand_shifter

---
 rtl/serial_operand_shifter.sv | 82 ++++++++
 tb/tb_serial_operand_shifter.sv | 113 +++++++++++
 2 files changed

// File: rtl/serial_operand_shifter.sv
// serial_operand_shifter: parallel-to-serial shifter feeding a 4-operand serial adder, LSB first, with zero guard flush per frame
// Ports: clock/reset (sync, active-high); in_valid/in_ready handshake; op_a..op_d WIDTH-bit operands;
//        a,b,c,d serial bits; bit_valid marks frame bits; frame_first/frame_last mark bit 0 and final guard bit.
module serial_operand_shifter #(
  parameter int WIDTH = 8,
  parameter int GUARD = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_c,
  input  logic [WIDTH-1:0] op_d,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             bit_valid,
  output logic             frame_first,
  output logic             frame_last
);
  localparam int CW = $clog2(WIDTH + GUARD);
  localparam logic [CW-1:0] DATA_END  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FRAME_END = CW'(WIDTH + GUARD - 1);
  localparam logic [CW-1:0] CLEAR_END = CW'(GUARD - 1);
  typedef enum logic [1:0] {CLEAR, IDLE, DATA, FLUSH} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0][WIDTH-1:0] sh_q, sh_d;
  logic [3:0] bits_d;
  logic accept;
  // The counter tracks the bit index within a frame (and the CLEAR cycle count),
  // so the registered output flags are decoded from next-state values.
  always_comb begin
    accept = in_valid & in_ready;
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    for (int i = 0; i < 4; i++) sh_d[i] = sh_q[i] >> 1;
    unique case (state_q)
      CLEAR: if (cnt_q == CLEAR_END) begin
        state_d = IDLE;
        cnt_d = '0;
      end
      IDLE: cnt_d = '0;
      DATA: if (cnt_q == DATA_END) state_d = FLUSH;
      FLUSH: if (cnt_q == FRAME_END) begin
        state_d = IDLE;
        cnt_d = '0;
      end
      default: state_d = CLEAR;
    endcase
    if (accept) begin
      state_d = DATA;
      cnt_d = '0;
      sh_d = {op_d, op_c, op_b, op_a};
    end
    for (int i = 0; i < 4; i++) bits_d[i] = (state_d == DATA) & sh_d[i][0];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      sh_q <= '0;
      in_ready <= 1'b0;
      {d, c, b, a} <= '0;
      bit_valid <= 1'b0;
      frame_first <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      in_ready <= (state_d == IDLE) || (state_d == FLUSH && cnt_d == FRAME_END);
      {d, c, b, a} <= bits_d;
      bit_valid <= (state_d == DATA) || (state_d == FLUSH);
      frame_first <= (state_d == DATA) && (cnt_d == '0);
      frame_last <= (state_d == FLUSH) && (cnt_d == FRAME_END);
    end
  end
endmodule

// File: tb/tb_serial_operand_shifter.sv
// tb_serial_operand_shifter: randomized and directed checks of serial_operand_shifter against a frame-queue reference model
module tb_serial_operand_shifter;
  localparam int W = 8;
  localparam int G = 2;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, in_valid, in_ready, a, b, c, d, bit_valid, frame_first, frame_last;
  logic [W-1:0] op_a, op_b, op_c, op_d;
  logic in_valid1, op1, in_ready1, a1, b1, c1, d1, bit_valid1, frame_first1, frame_last1;
  serial_operand_shifter #(.WIDTH(W), .GUARD(G)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .a(a), .b(b), .c(c), .d(d),
    .bit_valid(bit_valid), .frame_first(frame_first), .frame_last(frame_last)
  );
  serial_operand_shifter #(.WIDTH(1), .GUARD(2)) u_dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op1), .op_b(op1), .op_c(op1), .op_d(op1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .bit_valid(bit_valid1), .frame_first(frame_first1), .frame_last(frame_last1)
  );
  typedef struct packed {
    int idx;
    logic first;
    logic last;
    logic [3:0] bits;
  } ent_t;
  ent_t q[$];
  int sums[$];
  int clr = G;
  logic rdy_exp = 1'b0;
  int obs_sum = 0;
  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask
  // One clock cycle: drive inputs, let the edge sample them, advance the model, compare outputs.
  task automatic step(input logic r, input logic v, input logic [W-1:0] xa, xb, xc, xd);
    logic [W+G-1:0] za, zb, zc, zd;
    ent_t e;
    reset = r; in_valid = v; op_a = xa; op_b = xb; op_c = xc; op_d = xd;
    za = (W+G)'(xa); zb = (W+G)'(xb); zc = (W+G)'(xc); zd = (W+G)'(xd);
    @(posedge clock);
    if (r) begin
      q.delete(); sums.delete(); obs_sum = 0; clr = G;
    end else if (clr > 0) clr--;
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (v && rdy_exp) begin
        for (int i = 0; i < W + G; i++)
          q.push_back('{idx: i, first: i == 0, last: i == W + G - 1, bits: {zd[i], zc[i], zb[i], za[i]}});
        sums.push_back(int'(xa) + int'(xb) + int'(xc) + int'(xd));
      end
    end
    #1;
    e = (q.size() > 0) ? q[0] : '0;
    rdy_exp = (clr == 0) && (q.size() == 0 || q[0].last);
    check("ready", in_ready, rdy_exp);
    check("out", {bit_valid, frame_first, frame_last, d, c, b, a}, {q.size() > 0, e.first, e.last, e.bits});
    if (q.size() > 0) begin
      obs_sum += (int'(a) + int'(b) + int'(c) + int'(d)) << e.idx;
      if (e.last) begin
        check("sum", obs_sum, sums.pop_front());
        obs_sum = 0;
      end
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0);
  endtask
  logic [7:0] w1_exp[4] = '{8'h6F, 8'h40, 8'hD0, 8'h80};
  int w1_sum;
  initial begin
    in_valid1 = 1'b0; op1 = 1'b0;
    step(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    step(1'b1, 1'b0, '0, '0, '0, '0);
    idle(G + 1);
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    idle(W + G + 2);
    step(1'b0, 1'b1, 8'h01, 8'h02, 8'h04, 8'h08);
    for (int i = 0; i < W + G; i++) step(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00);
    idle(W + G + 2);
    step(1'b0, 1'b1, 8'hA5, 8'h3C, 8'h0F, 8'h81);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    idle(G + 2);
    step(1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 8'h01);
    idle(3);
    step(1'b1, 1'b1, 8'h55, 8'h55, 8'h55, 8'h55);
    idle(G + 1);
    step(1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 8'h01);
    idle(W + G + 2);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    step(1'b1, 1'b0, '0, '0, '0, '0);
    idle(G);
    check("w1_ready", in_ready1, 1'b1);
    in_valid1 = 1'b1; op1 = 1'b1;
    w1_sum = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, '0, '0, '0, '0);
      in_valid1 = 1'b0;
      check("w1_out", {in_ready1, bit_valid1, frame_first1, frame_last1, a1, b1, c1, d1}, w1_exp[k]);
      if (bit_valid1) w1_sum += (int'(a1) + int'(b1) + int'(c1) + int'(d1)) << k;
    end
    check("w1_sum", w1_sum, 4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
